// File: rtl/mvu_pe_acc_stream.sv
// Streaming dot-product accumulator behind the PE adder tree: folds SF adder-tree
// sums into one registered result with a valid/ready output handshake.
module mvu_pe_acc_stream #(
    parameter int TDstI  = 16,
    parameter int TDstO  = 24,
    parameter int SF     = 8,
    parameter int OP_SGN = 1
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [TDstI-1:0] in_add,
    input  logic             in_v,
    output logic             in_rdy,
    output logic [TDstO-1:0] out_acc,
    output logic             out_v,
    input  logic             out_rdy
);

    localparam int CW = (SF > 1) ? $clog2(SF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SF - 1);

    logic [TDstO-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TDstO-1:0] out_acc_q, out_acc_d;
    logic             out_v_q, out_v_d;

    logic [TDstO-1:0] ext_w;
    logic [TDstO-1:0] sum_w;
    logic             last_w;
    logic             accept_w;

    always_comb begin
        if (OP_SGN != 0) ext_w = TDstO'($signed(in_add));
        else             ext_w = TDstO'(in_add);
    end

    // The first fold restarts the sum, so a stale acc never leaks into a new row.
    assign sum_w    = (cnt_q == '0) ? ext_w : acc_q + ext_w;
    assign last_w   = (cnt_q == CNT_LAST);
    assign in_rdy   = !last_w || !out_v_q || out_rdy;
    assign accept_w = in_v && in_rdy;

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_acc_d = out_acc_q;
        out_v_d   = out_v_q;
        if (out_v_q && out_rdy) out_v_d = 1'b0;
        if (accept_w) begin
            acc_d = sum_w;
            if (last_w) begin
                out_acc_d = sum_w;
                out_v_d   = 1'b1;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            out_acc_q <= '0;
            out_v_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_acc_q <= out_acc_d;
            out_v_q   <= out_v_d;
        end
    end

    assign out_acc = out_acc_q;
    assign out_v   = out_v_q;

endmodule

// File: doc/mvu_pe_acc_stream.md
# mvu_pe_acc_stream

Per-PE streaming accumulator directly downstream of the PE adder tree in the Matrix-Vector-Multiplication Unit. Each cycle it takes one adder-tree sum, which is the SIMD lane products reduced for one synapse fold. It accumulates SF consecutive sums into one dot-product result for the current output row. The result is presented on a registered output with a valid/ready handshake. Backpressure stalls only the beat that completes a dot product.

## Interface
- TDstI, 16: width of the adder-tree sum on in_add.
- TDstO, 24: accumulator and output width; must be >= TDstI.
- SF, 8: synapse fold, i.e. input beats per output (MatrixW/SIMD); must be >= 1.
- OP_SGN, 1: 1 = in_add is two's complement and is sign-extended to TDstO; 0 = unsigned and zero-extended.

Ports:
- aclk  input  1  clock; all state updates on the rising edge.
- areset  input  1  reset, synchronous, active-high.
- in_add  input  TDstI  adder-tree sum for the current fold.
- in_v  input  1  in_add valid.
- in_rdy  output  1  accumulator can accept in_add this cycle.
- out_acc  output  TDstO  accumulated dot product (registered).
- out_v  output  1  out_acc valid.
- out_rdy  input  1  downstream accepts out_acc.

## Operation
- Internal state:
  - acc [TDstO-1:0], the partial sum.
  - cnt [clog2(SF) or 1 bit min], the fold index 0..SF-1.
  - The out_acc/out_v register.
- A beat is accepted when in_v && in_rdy. No state changes when no beat is accepted, except that out_v clears on drain.
- ext(x) = sign- or zero-extension of in_add to TDstO, selected by OP_SGN.
- Accepted beat with cnt==0: acc <= ext(in_add). The previous acc is discarded.
- Accepted beat with 0<cnt<SF-1: acc <= acc + ext(in_add).
- Accumulator arithmetic is modulo 2^TDstO. There is no saturation and no overflow flag.
- Accepted beat with cnt==SF-1:
  - out_acc <= (cnt==0 ? ext(in_add) : acc + ext(in_add)).
  - out_v <= 1.
  - cnt <= 0.
- On any other accepted beat, cnt <= cnt+1.
- SF==1: every beat is both first and last, so out_acc <= ext(in_add).
- in_rdy = 1 when cnt != SF-1. When cnt == SF-1, in_rdy = !out_v || out_rdy. This is combinational from out_rdy.
- Output drain: out_v && out_rdy with no last beat accepted in the same cycle -> out_v <= 0. out_acc holds its last value.
- Simultaneous drain and last-beat accept -> out_v stays 1 and out_acc takes the new result. No bubble and no lost result.
- out_v is never deasserted without out_rdy. out_acc is stable while out_v && !out_rdy.
- in_add is ignored when in_v == 0. in_v may drop mid-vector; the partial sum and cnt hold indefinitely.

## Timing
- Reset (areset high at a rising edge): acc=0, cnt=0, out_acc=0, out_v=0.
  - in_rdy is therefore 1 after reset.
  - Reset mid-vector discards the partial sum. The next accepted beat is treated as cnt==0.
- Reset has priority over all handshakes in the same cycle.
- Latency: out_v rises on the edge that accepts the last beat, so out_acc is visible 1 cycle after the last beat is presented.
- Throughput: one result per SF accepted beats. Back-to-back vectors at full rate are sustained when out_rdy is held at 1.
- Stall: with out_v=1, out_rdy=0 and cnt==SF-1, in_rdy=0. The last beat waits, and acc/cnt are unchanged until out_rdy rises.

## Test plan
- Signed basic, TDstI=8, TDstO=12, SF=4, OP_SGN=1, out_rdy=1: beats 3, 5, -2 (0xFE), 10 on consecutive cycles -> out_acc=16 (0x010) with out_v=1 for exactly 1 cycle, on the cycle after the 4th beat.
- Unsigned wrap, TDstI=8, TDstO=10, SF=8, OP_SGN=0: eight beats of 255 -> out_acc=1016 (2040 mod 1024).
- Backpressure: out_rdy=0 after the first result (16 from the signed-basic test), then a second vector 1, 1, 1, 1:
  - in_rdy=1 for beats 1-3 and 0 at beat 4; out_acc holds 16.
  - Raise out_rdy -> the 4th beat is accepted that cycle and out_acc=4 on the next cycle with out_v continuously 1.
- Gapped input, SF=4: beats 7, gap of 3 cycles with in_v=0, then 7, 7, 7 -> out_acc=28. No out_v during the gap.
- Reset mid-vector, SF=4: beats 100, 100, assert areset for 1 cycle, then beats 1, 2, 3, 4:
  - outputs are 0 with out_v=0 after reset;
  - the result is 10, not 210.
- SF=1, OP_SGN=1: stream -1, 2, -3 with out_rdy=1 -> out_acc = -1, 2, -3 on successive cycles and out_v constantly 1.
